rr_prio_arbiter: RTL and testbench
==================================

Name: rr_prio_arbiter

Overview:
- Registered N-way arbiter combining multi-level priority with round-robin fairness among equal-priority requesters.
- A grant is held for a whole transaction: the owner keeps it while its req stays high.
- A hold timer preempts an owner that monopolises the resource.
- Sits in front of shared resources (bus, memory port) as the general successor of the single-cycle one-hot-priority arbiter.

Parameters:
- N, 4, number of requesters (N >= 1).
- PRIO_W, 2, width of each requester's priority level; higher value wins.
- MAX_HOLD, 16, maximum consecutive grant cycles before preemption; 0 disables preemption.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request per master; held high for the duration of a transaction.
- prio  in  N*PRIO_W  priority level per master; master i uses bits [i*PRIO_W +: PRIO_W].
- grant  out  N  one-hot grant (or zero), registered.
- grant_valid  out  1  high when any grant bit is set.
- grant_id  out  IDW  index of the granted master; IDW = max(1, clog2(N)).

Behaviour:
- Reset:
  - grant=0, grant_valid=0, grant_id=0.
  - rr_ptr=0, hold_cnt=0, state=IDLE.
  - Reset asserted mid-grant clears the grant at that edge, with no pending state retained.
- States: IDLE (no owner), BUSY (owner held in grant_id).
- Arbitration function (combinational, over candidate mask C):
  - Find the maximum prio level among masters in C.
  - Among masters at that level, pick the first index at or after rr_ptr, scanning circularly (rr_ptr, rr_ptr+1, ... wrapping mod N).
  - prio is sampled only in arbitration cycles; changes during BUSY are ignored.
- IDLE:
  - If req != 0, arbitrate with C = req.
  - At the next edge: grant = onehot(winner), state = BUSY, rr_ptr = (winner+1) mod N, hold_cnt = 0.
  - Latency from req rise to grant is exactly 1 cycle.
  - If req == 0, all outputs stay 0.
- BUSY, owner req still high, no timeout:
  - Grant is held unchanged.
  - hold_cnt increments, saturating at MAX_HOLD-1.
- BUSY, owner req low (release): arbitrate in the same cycle with C = req.
  - If C != 0: the new grant appears at the next edge (no bubble); update rr_ptr, reset hold_cnt.
  - If C == 0: next edge clears the grant, state = IDLE.
- BUSY, timeout (MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, owner req high): arbitrate with C = req minus owner.
  - If C != 0: the grant switches to the winner at the next edge, whatever its priority relative to the owner. The preempted owner must re-request (holding req high is enough) and competes normally later.
  - If C == 0: the owner keeps the grant and hold_cnt resets to 0.
- Simultaneous release and timeout: the release rule applies.
- Output invariants:
  - grant is never multi-hot.
  - grant_valid == |grant.
  - grant_id matches grant whenever grant_valid = 1.
- N=1:
  - rr_ptr is constant 0.
  - Preemption never switches (C always empty); the grant follows req with 1-cycle latency.

Decomposition:
- Package arb_pkg:
  - arb_state_e enum {IDLE, BUSY}.
  - Helper function for the IDW computation.
- Sub-module rr_pick:
  - Purely combinational: inputs mask, prio, ptr; outputs valid, idx.
  - Implements the max-level filter plus circular first-set search.
  - Reusable by later multi-port arbiters.
- Top level holds the FSM, rr_ptr, hold_cnt and output registers.

Test Plan (N=4, PRIO_W=2, MAX_HOLD=4 unless stated):
- Reset, then req=4'b0000 for 5 cycles -> grant=0, grant_valid=0, grant_id=0 throughout. Assert rst while master 2 is granted -> grant=0 at the next edge.
- Equal priority (all prio=1), req=4'b1111, each owner drops req after 1 cycle of grant and re-raises it -> grant order 0,1,2,3,0, with no idle cycle between grants.
- Levels prio={3,1,1,2} (masters 3..0), req=4'b1111 -> first grant master 3 (level 3). After its release -> master 0 (level 2). Then masters 1 and 2 alternate by rr_ptr.
- Preemption: master 1 holds req high, master 2 requests from cycle 0 -> master 1 granted for exactly 4 cycles, then grant switches to master 2. Same with MAX_HOLD=0 -> master 1 keeps the grant indefinitely.
- Lone owner timeout: only master 0 requests for 12 cycles -> grant stays 4'b0001 continuously, with no glitch at the timeout boundaries.
- Latency and wrap: rr_ptr=3 (after a grant to master 2), req=4'b0001 rises at cycle t -> grant=4'b0001 and grant_id=0 at t+1, and rr_ptr becomes 1.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the round-robin priority arbiter
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Index width; a single requester still gets a 1-bit id.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_prio_arbiter_if.sv
// rtl/rr_prio_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface rr_prio_arbiter_if #(
    parameter int N      = 4,
    parameter int PRIO_W = 2
);
    import arb_pkg::*;

    localparam int IDW = idw(N);

    logic [N-1:0]        req;
    logic [N*PRIO_W-1:0] prio;
    logic [N-1:0]        grant;
    logic                grant_valid;
    logic [IDW-1:0]      grant_id;

    modport master (
        output req,
        output prio,
        input  grant,
        input  grant_valid,
        input  grant_id
    );

    modport slave (
        input  req,
        input  prio,
        output grant,
        output grant_valid,
        output grant_id
    );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational max-priority filter followed by a circular first-set search
module rr_pick
    import arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int PRIO_W = 2,
    localparam int IDW   = idw(N)
) (
    input  logic [N-1:0]        mask_i,
    input  logic [N*PRIO_W-1:0] prio_i,
    input  logic [IDW-1:0]      ptr_i,
    output logic                valid_o,
    output logic [IDW-1:0]      idx_o
);

    logic [PRIO_W-1:0] max_lvl;
    logic [N-1:0]      top_mask;
    logic [N-1:0]      rot;
    logic [IDW:0]      sum;
    logic              found;

    always_comb begin
        max_lvl = '0;
        for (int i = 0; i < N; i++) begin
            if (mask_i[i] && (prio_i[i*PRIO_W +: PRIO_W] > max_lvl)) begin
                max_lvl = prio_i[i*PRIO_W +: PRIO_W];
            end
        end
        top_mask = '0;
        for (int i = 0; i < N; i++) begin
            top_mask[i] = mask_i[i] && (prio_i[i*PRIO_W +: PRIO_W] == max_lvl);
        end
    end

    // Rotating by ptr turns the circular search into a plain lowest-bit search.
    always_comb begin
        rot   = N'({top_mask, top_mask} >> ptr_i);
        idx_o = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_i} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(N)) begin
                    sum = sum - (IDW+1)'(N);
                end
                idx_o = sum[IDW-1:0];
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/rr_prio_arbiter.sv
// rtl/rr_prio_arbiter.sv - registered priority + round-robin arbiter with transaction hold and preemption timer
module rr_prio_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int PRIO_W   = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    rr_prio_arbiter_if.slave bus
);

    localparam int IDW = idw(N);
    localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    arb_state_e     state_q;
    logic [N-1:0]   grant_q;
    logic           grant_valid_q;
    logic [IDW-1:0] grant_id_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [HW-1:0]  hold_cnt_q;

    logic [N-1:0]   grant_d;
    logic [IDW-1:0] rr_ptr_d;
    logic [N-1:0]   cand;
    logic           owner_req;
    logic           timeout;
    logic           arb_cycle;
    logic           pick_valid;
    logic [IDW-1:0] pick_idx;

    assign owner_req = bus.req[grant_id_q];
    assign timeout   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign arb_cycle = (state_q == IDLE) || !owner_req || timeout;

    // On a timeout with the owner still requesting, the owner sits out one arbitration.
    always_comb begin
        cand = bus.req;
        if ((state_q == BUSY) && owner_req && timeout) begin
            cand = bus.req & ~grant_q;
        end
    end

    rr_pick #(
        .N      (N),
        .PRIO_W (PRIO_W)
    ) u_pick (
        .mask_i  (cand),
        .prio_i  (bus.prio),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign grant_d  = N'(1) << pick_idx;
    assign rr_ptr_d = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
        end else if (arb_cycle && pick_valid) begin
            state_q       <= BUSY;
            grant_q       <= grant_d;
            grant_valid_q <= 1'b1;
            grant_id_q    <= pick_idx;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= '0;
        end else if (state_q == BUSY) begin
            if (!owner_req) begin
                state_q       <= IDLE;
                grant_q       <= '0;
                grant_valid_q <= 1'b0;
                grant_id_q    <= '0;
                hold_cnt_q    <= '0;
            end else if (timeout) begin
                hold_cnt_q <= '0;
            end else if (hold_cnt_q != HOLD_LAST) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// tb/tb_rr_prio_arbiter.sv - directed self-checking bench for rr_prio_arbiter
module tb_rr_prio_arbiter;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    rr_prio_arbiter_if #(.N(4), .PRIO_W(2)) a_if ();
    rr_prio_arbiter_if #(.N(4), .PRIO_W(2)) b_if ();

    rr_prio_arbiter #(.N(4), .PRIO_W(2), .MAX_HOLD(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    rr_prio_arbiter #(.N(4), .PRIO_W(2), .MAX_HOLD(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] r, input logic [7:0] p);
        a_if.req  = r;
        b_if.req  = r;
        a_if.prio = p;
        b_if.prio = p;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] g, input logic v,
                       input logic [1:0] id, input logic [3:0] exp_g);
        logic [1:0] exp_id;
        exp_id = 2'd0;
        for (int i = 0; i < 4; i++) if (exp_g[i]) exp_id = 2'(i);
        n_cmp++;
        assert (g === exp_g) else begin
            n_err++;
            $error("FAIL %s grant: observed %b expected %b", tag, g, exp_g);
        end
        n_cmp++;
        assert (v === (|exp_g)) else begin
            n_err++;
            $error("FAIL %s grant_valid: observed %b expected %b", tag, v, |exp_g);
        end
        if (exp_g != 4'b0000) begin
            n_cmp++;
            assert (id === exp_id) else begin
                n_err++;
                $error("FAIL %s grant_id: observed %0d expected %0d", tag, id, exp_id);
            end
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] exp_g);
        chk(tag, a_if.grant, a_if.grant_valid, a_if.grant_id, exp_g);
    endtask

    task automatic chk_b(input string tag, input logic [3:0] exp_g);
        chk(tag, b_if.grant, b_if.grant_valid, b_if.grant_id, exp_g);
    endtask

    initial begin
        rst = 1'b1;
        drive(4'b0000, 8'h55);
        repeat (3) tick();
        chk_a("reset", 4'b0000);
        n_cmp++;
        assert (a_if.grant_id === 2'd0) else begin
            n_err++;
            $error("FAIL reset grant_id: observed %0d expected 0", a_if.grant_id);
        end
        rst = 1'b0;

        for (int c = 0; c < 5; c++) begin
            tick();
            chk_a("idle_no_req", 4'b0000);
        end

        // reset in the middle of a grant to master 2
        drive(4'b0100, 8'h55);
        tick();
        chk_a("pre_rst_grant2", 4'b0100);
        rst = 1'b1;
        tick();
        chk_a("rst_mid_grant", 4'b0000);
        rst = 1'b0;
        drive(4'b0000, 8'h55);
        tick();
        chk_a("after_rst_idle", 4'b0000);

        // equal priority: owner drops for one cycle, order 0,1,2,3,0 without bubbles
        drive(4'b1111, 8'h55);
        tick();
        chk_a("rr_first", 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            drive(4'b1111 & ~(4'b0001 << ((k - 1) % 4)), 8'h55);
            tick();
            chk_a($sformatf("rr_step%0d", k), 4'b0001 << (k % 4));
        end
        drive(4'b0000, 8'h55);
        tick();
        chk_a("rr_release_idle", 4'b0000);

        // levels m3=3 m2=1 m1=1 m0=2, rr_ptr=1
        drive(4'b1111, 8'hD6);
        tick();
        chk_a("lvl_top3", 4'b1000);
        drive(4'b0111, 8'hD6);
        tick();
        chk_a("lvl_next0", 4'b0001);
        drive(4'b0110, 8'hD6);
        tick();
        chk_a("lvl_tie_m1", 4'b0010);
        drive(4'b0000, 8'hD6);
        tick();
        chk_a("lvl_idle1", 4'b0000);
        drive(4'b0110, 8'hD6);
        tick();
        chk_a("lvl_tie_m2", 4'b0100);
        drive(4'b0000, 8'hD6);
        tick();
        chk_a("lvl_idle2", 4'b0000);
        drive(4'b0110, 8'hD6);
        tick();
        chk_a("lvl_tie_m1_again", 4'b0010);
        drive(4'b0000, 8'hD6);
        tick();
        chk_a("lvl_idle3", 4'b0000);

        // preemption: m1 (level 2) holds, m2 (level 1) waits; dut_b never preempts
        drive(4'b0110, 8'h59);
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk_a($sformatf("preempt_c%0d", c), (c <= 4) ? 4'b0010 : 4'b0100);
            chk_b($sformatf("nohold_c%0d", c), 4'b0010);
        end
        drive(4'b0000, 8'h59);
        tick();
        chk_a("preempt_idle", 4'b0000);
        chk_b("nohold_idle", 4'b0000);

        // lone owner across several timeout boundaries
        drive(4'b0001, 8'h55);
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk_a($sformatf("lone_c%0d", c), 4'b0001);
        end
        drive(4'b0000, 8'h55);
        tick();
        chk_a("lone_idle", 4'b0000);

        // latency and pointer wrap: grant m2 -> rr_ptr=3, then m0 -> rr_ptr=1
        drive(4'b0100, 8'h55);
        tick();
        chk_a("wrap_grant2", 4'b0100);
        drive(4'b0000, 8'h55);
        tick();
        chk_a("wrap_idle", 4'b0000);
        drive(4'b0001, 8'h55);
        tick();
        chk_a("wrap_latency_m0", 4'b0001);
        drive(4'b0000, 8'h55);
        tick();
        chk_a("wrap_idle2", 4'b0000);
        drive(4'b1111, 8'h55);
        tick();
        chk_a("wrap_ptr_is_1", 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
